instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/fetch_pkg.sv | 18 +
 rtl/instruction_fetch_ifid_reg.sv | 39 +++
 rtl/instruction_fetch.sv | 101 ++++++++++
 tb/tb_instruction_fetch.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch stage: FSM encodings, special
// instruction words and the default reset PC.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ST_W = 2;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_RUN    = 2'd1;
  localparam state_t ST_HALTED = 2'd2;

  localparam logic [XLEN-1:0] ECALL_INST       = 32'h0000_0073;
  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_ifid_reg.sv
// IF/ID pipeline register: load wins over flush; flush only drops valid,
// leaving the last instruction and its PC in place.
module ifid_reg
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] inst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] pc_o,
  output logic            valid_o
);

  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] pc_q;
  logic            valid_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      inst_q  <= NOP_INST;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      inst_q  <= inst_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end
  end

  assign inst_o  = inst_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC sequencing, redirect/stall handling, ECALL halt
// and the fetch counter, feeding an IF/ID register.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_dout,
  output logic [XLEN-1:0] ifid_inst,
  output logic [XLEN-1:0] ifid_pc,
  output logic            ifid_valid,
  output logic            halted,
  output logic            misalign_err,
  output logic [XLEN-1:0] fetch_count
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] count_q, count_d;
  logic            misalign_q, misalign_d;
  logic            halted_q;
  logic            load_c;
  logic            flush_c;

  // Next-state logic; a redirect beats stall in both RUN and HALTED.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    misalign_d = misalign_q;
    load_c     = 1'b0;
    flush_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_RUN;
      end
      ST_RUN, ST_HALTED: begin
        if (redirect_valid) begin
          state_d    = ST_RUN;
          pc_d       = {redirect_target[XLEN-1:2], 2'b00};
          flush_c    = 1'b1;
          misalign_d = misalign_q | (redirect_target[1:0] != 2'b00);
        end else if (!stall) begin
          if (state_q == ST_RUN) begin
            load_c  = 1'b1;
            pc_d    = pc_q + XLEN'(4);
            count_d = count_q + XLEN'(1);
            if (imem_dout == ECALL_INST) begin
              state_d = ST_HALTED;
            end
          end else begin
            flush_c = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      count_q    <= '0;
      misalign_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
      halted_q   <= (state_d == ST_HALTED);
    end
  end

  ifid_reg u_ifid_reg (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load_c),
    .flush_i (flush_c),
    .inst_i  (imem_dout),
    .pc_i    (pc_q),
    .inst_o  (ifid_inst),
    .pc_o    (ifid_pc),
    .valid_o (ifid_valid)
  );

  assign imem_addr    = pc_q;
  assign halted       = halted_q;
  assign misalign_err = misalign_q;
  assign fetch_count  = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, sequential fetch, stall,
// redirect, ECALL halt, mid-run reset and PC wrap.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr, imem_dout, ifid_inst, ifid_pc, fetch_count;
  logic        ifid_valid, halted, misalign_err;

  logic        reset_b;
  logic [31:0] imem_addr_b, imem_dout_b, ifid_inst_b, ifid_pc_b, fetch_count_b;
  logic        ifid_valid_b, halted_b, misalign_err_b;

  logic [31:0] mem [64];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  assign imem_dout   = mem[imem_addr[7:2]];
  assign imem_dout_b = mem[imem_addr_b[7:2]];

  instruction_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .imem_addr(imem_addr), .imem_dout(imem_dout),
    .ifid_inst(ifid_inst), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid),
    .halted(halted), .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .reset(reset_b), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .imem_addr(imem_addr_b), .imem_dout(imem_dout_b),
    .ifid_inst(ifid_inst_b), .ifid_pc(ifid_pc_b), .ifid_valid(ifid_valid_b),
    .halted(halted_b), .misalign_err(misalign_err_b), .fetch_count(fetch_count_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; reset_b = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0;
    step(); step();
    n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr got %h exp %h", imem_addr, 32'h0); end
    n_vec++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", ifid_valid); end
    n_vec++; if (ifid_inst !== 32'h13) begin n_err++; $display("FAIL rst_inst got %h exp 00000013", ifid_inst); end
    n_vec++; if (ifid_pc !== 32'h0) begin n_err++; $display("FAIL rst_pc got %h exp 0", ifid_pc); end
    n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL rst_halted got %b exp 0", halted); end
    n_vec++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL rst_misalign got %b exp 0", misalign_err); end
    n_vec++; if (fetch_count !== 32'h0) begin n_err++; $display("FAIL rst_count got %0d exp 0", fetch_count); end
  endtask

  task automatic test_fetch();
    reset = 1'b1;
    step();
    n_vec++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid got %b exp 0", ifid_valid); end
    n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL idle_addr got %h exp 0", imem_addr); end
    step();
    n_vec++; if (ifid_inst !== 32'h0050_0093) begin n_err++; $display("FAIL f1_inst got %h exp 00500093", ifid_inst); end
    n_vec++; if (ifid_pc !== 32'h0) begin n_err++; $display("FAIL f1_pc got %h exp 0", ifid_pc); end
    n_vec++; if (ifid_valid !== 1'b1) begin n_err++; $display("FAIL f1_valid got %b exp 1", ifid_valid); end
    n_vec++; if (fetch_count !== 32'd1) begin n_err++; $display("FAIL f1_count got %0d exp 1", fetch_count); end
    step();
    n_vec++; if (ifid_pc !== 32'h4) begin n_err++; $display("FAIL f2_pc got %h exp 4", ifid_pc); end
    n_vec++; if (ifid_inst !== 32'h0010_0113) begin n_err++; $display("FAIL f2_inst got %h exp 00100113", ifid_inst); end
    n_vec++; if (fetch_count !== 32'd2) begin n_err++; $display("FAIL f2_count got %0d exp 2", fetch_count); end
    n_vec++; if (imem_addr !== 32'h8) begin n_err++; $display("FAIL f2_addr got %h exp 8", imem_addr); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (imem_addr !== 32'h8) begin n_err++; $display("FAIL stall_addr[%0d] got %h exp 8", i, imem_addr); end
      n_vec++; if (ifid_pc !== 32'h4 || ifid_inst !== 32'h0010_0113 || ifid_valid !== 1'b1) begin
        n_err++; $display("FAIL stall_ifid[%0d] got pc=%h inst=%h v=%b exp pc=4 inst=00100113 v=1", i, ifid_pc, ifid_inst, ifid_valid);
      end
      n_vec++; if (fetch_count !== 32'd2) begin n_err++; $display("FAIL stall_count[%0d] got %0d exp 2", i, fetch_count); end
    end
    stall = 1'b0;
  endtask

  task automatic test_redirect();
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
    step();
    n_vec++; if (imem_addr !== 32'h40) begin n_err++; $display("FAIL redir_addr got %h exp 40", imem_addr); end
    n_vec++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL redir_valid got %b exp 0", ifid_valid); end
    n_vec++; if (ifid_inst !== 32'h0010_0113 || ifid_pc !== 32'h4) begin
      n_err++; $display("FAIL redir_hold got inst=%h pc=%h exp inst=00100113 pc=4", ifid_inst, ifid_pc);
    end
    n_vec++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL redir_mis0 got %b exp 0", misalign_err); end
    redirect_target = 32'h42;
    step();
    n_vec++; if (imem_addr !== 32'h40) begin n_err++; $display("FAIL mis_addr got %h exp 40", imem_addr); end
    n_vec++; if (misalign_err !== 1'b1) begin n_err++; $display("FAIL mis_set got %b exp 1", misalign_err); end
    redirect_valid = 1'b0; stall = 1'b0;
    step();
    n_vec++; if (ifid_inst !== 32'h0040_0293 || ifid_pc !== 32'h40 || ifid_valid !== 1'b1) begin
      n_err++; $display("FAIL post_redir got inst=%h pc=%h v=%b exp inst=00400293 pc=40 v=1", ifid_inst, ifid_pc, ifid_valid);
    end
    n_vec++; if (fetch_count !== 32'd3) begin n_err++; $display("FAIL post_redir_count got %0d exp 3", fetch_count); end
    n_vec++; if (misalign_err !== 1'b1) begin n_err++; $display("FAIL mis_sticky got %b exp 1", misalign_err); end
  endtask

  task automatic test_ecall();
    redirect_valid = 1'b1; redirect_target = 32'h8;
    step();
    redirect_valid = 1'b0;
    step(); step(); step();
    n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL ecall_halted got %b exp 1", halted); end
    n_vec++; if (ifid_inst !== 32'h73 || ifid_pc !== 32'h10 || ifid_valid !== 1'b1) begin
      n_err++; $display("FAIL ecall_ifid got inst=%h pc=%h v=%b exp inst=73 pc=10 v=1", ifid_inst, ifid_pc, ifid_valid);
    end
    n_vec++; if (imem_addr !== 32'h14) begin n_err++; $display("FAIL ecall_addr got %h exp 14", imem_addr); end
    n_vec++; if (fetch_count !== 32'd6) begin n_err++; $display("FAIL ecall_count got %0d exp 6", fetch_count); end
    stall = 1'b1;
    step();
    n_vec++; if (ifid_valid !== 1'b1 || halted !== 1'b1) begin
      n_err++; $display("FAIL halt_stall got v=%b h=%b exp v=1 h=1", ifid_valid, halted);
    end
    stall = 1'b0;
    step();
    n_vec++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL halt_flush got %b exp 0", ifid_valid); end
    step();
    n_vec++; if (imem_addr !== 32'h14 || fetch_count !== 32'd6 || halted !== 1'b1) begin
      n_err++; $display("FAIL halt_hold got addr=%h cnt=%0d h=%b exp addr=14 cnt=6 h=1", imem_addr, fetch_count, halted);
    end
    redirect_valid = 1'b1; redirect_target = 32'h0;
    step();
    n_vec++; if (halted !== 1'b0 || imem_addr !== 32'h0 || ifid_valid !== 1'b0) begin
      n_err++; $display("FAIL resume_redir got h=%b addr=%h v=%b exp h=0 addr=0 v=0", halted, imem_addr, ifid_valid);
    end
    redirect_valid = 1'b0;
    step();
    n_vec++; if (ifid_inst !== 32'h0050_0093 || ifid_pc !== 32'h0 || fetch_count !== 32'd7) begin
      n_err++; $display("FAIL resume_fetch got inst=%h pc=%h cnt=%0d exp inst=00500093 pc=0 cnt=7", ifid_inst, ifid_pc, fetch_count);
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b0; stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h42;
    step();
    n_vec++; if (imem_addr !== 32'h0 || ifid_valid !== 1'b0 || ifid_inst !== 32'h13 || ifid_pc !== 32'h0) begin
      n_err++; $display("FAIL mid_rst_ifid got addr=%h v=%b inst=%h pc=%h exp addr=0 v=0 inst=13 pc=0", imem_addr, ifid_valid, ifid_inst, ifid_pc);
    end
    n_vec++; if (misalign_err !== 1'b0 || fetch_count !== 32'h0 || halted !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_state got mis=%b cnt=%0d h=%b exp 0 0 0", misalign_err, fetch_count, halted);
    end
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
  endtask

  task automatic test_wrap();
    reset_b = 1'b0;
    step();
    n_vec++; if (imem_addr_b !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_rst_addr got %h exp fffffffc", imem_addr_b); end
    reset_b = 1'b1;
    step(); step();
    n_vec++; if (ifid_pc_b !== 32'hFFFF_FFFC || ifid_valid_b !== 1'b1) begin
      n_err++; $display("FAIL wrap_ifid got pc=%h v=%b exp pc=fffffffc v=1", ifid_pc_b, ifid_valid_b);
    end
    n_vec++; if (imem_addr_b !== 32'h0) begin n_err++; $display("FAIL wrap_addr got %h exp 0", imem_addr_b); end
    n_vec++; if (misalign_err_b !== 1'b0 || halted_b !== 1'b0) begin
      n_err++; $display("FAIL wrap_flags got mis=%b h=%b exp 0 0", misalign_err_b, halted_b);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
    mem[0]  = 32'h0050_0093;
    mem[1]  = 32'h0010_0113;
    mem[2]  = 32'h0020_0193;
    mem[3]  = 32'h0030_0213;
    mem[4]  = 32'h0000_0073;
    mem[16] = 32'h0040_0293;
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_ecall();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
